// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the CPU data port and the word-addressed data RAM.
// Stores queue in a FIFO, drain one per cycle when the RAM is free, and forward to loads.
module dmem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                cpu_addr,
  input  logic [31:0]                cpu_wdata,
  input  logic                       cpu_we,
  output logic [31:0]                cpu_rdata,
  output logic                       stall,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [31:0]                ram_wdata,
  output logic                       ram_we,
  input  logic                       ram_busy,
  input  logic [31:0]                ram_rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [31:0]       data_mem [DEPTH];
  logic [PW-1:0]     head_reg;
  logic [PW-1:0]     tail_reg;
  logic [CW-1:0]     count_reg;

  logic [ADDR_W-1:0] cpu_word;
  logic              drain;
  logic              accept;

  // Only the word-index slice of the byte address takes part in matching.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

  assign cpu_word = cpu_addr[ADDR_W+1:2];
  assign empty    = (count_reg == '0);
  assign drain    = !empty && !ram_busy && rst;
  assign accept   = cpu_we && rst && ((count_reg < DEPTH_C) || drain);
  assign stall    = cpu_we && rst && !accept;

  assign ram_we    = drain;
  assign ram_addr  = addr_mem[head_reg];
  assign ram_wdata = data_mem[head_reg];
  assign count     = count_reg;

  // Age-ordered view: slot gi is the entry gi positions behind the head.
  logic [PW-1:0] age_idx [DEPTH];
  logic [DEPTH-1:0] age_hit;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age_idx[gi] = head_reg + PW'(gi);
      assign age_hit[gi] = (CW'(gi) < count_reg) && (addr_mem[age_idx[gi]] == cpu_word);
    end
  endgenerate

  // Later (younger) hits override older ones; the incoming store is not visible yet.
  always_comb begin
    cpu_rdata = ram_rdata;
    for (int i = 0; i < DEPTH; i++) begin
      if (age_hit[i]) cpu_rdata = data_mem[age_idx[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_mem[tail_reg] <= cpu_word;
      data_mem[tail_reg] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (drain)  head_reg <= head_reg + 1'b1;
      if (accept) tail_reg <= tail_reg + 1'b1;
      if (accept && !drain)      count_reg <= count_reg + 1'b1;
      else if (drain && !accept) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed self-checking bench for dmem_store_buffer (DEPTH=4, ADDR_W=14).
module tb_dmem_store_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic        ram_busy;
  logic [31:0] ram_rdata;
  logic [2:0]  count;
  logic        empty;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_store_buffer #(.DEPTH(4), .ADDR_W(14)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_busy(ram_busy), .ram_rdata(ram_rdata),
    .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1; ram_busy = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got=%0b exp=0", stall); end
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL rst_ram_we got=%0b exp=0", ram_we); end
    tick();
    rst = 1'b1; cpu_we = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got=%0b exp=1", empty); end
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL rst_ram_we_after got=%0b exp=0", ram_we); end
    $display("test_reset done");
  endtask

  task automatic test_single_store();
    ram_busy = 1'b0; cpu_we = 1'b1; cpu_addr = 32'h0000_0010; cpu_wdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL single_stall got=%0b exp=0", stall); end
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL single_no_passthru got=%0b exp=0", ram_we); end
    tick();
    cpu_we = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL single_count got=%0d exp=1", count); end
    n_cmp++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL single_ram_we got=%0b exp=1", ram_we); end
    n_cmp++; if (ram_addr !== 14'd4) begin n_bad++; $display("FAIL single_ram_addr got=%0d exp=4", ram_addr); end
    n_cmp++; if (ram_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_ram_wdata got=%h exp=deadbeef", ram_wdata); end
    tick();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL single_count_after got=%0d exp=0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL single_empty got=%0b exp=1", empty); end
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL single_ram_we_after got=%0b exp=0", ram_we); end
    $display("test_single_store done");
  endtask

  task automatic test_fill_stall();
    ram_busy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cpu_we = 1'b1; cpu_addr = 32'(k * 4); cpu_wdata = 32'h100 + 32'(k);
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fill_stall_%0d got=%0b exp=0", k, stall); end
      tick();
    end
    cpu_addr = 32'd20; cpu_wdata = 32'h105;
    #1;
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fill_count got=%0d exp=4", count); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL fill_stall_full got=%0b exp=1", stall); end
    tick();
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fill_count_hold got=%0d exp=4", count); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL fill_stall_hold got=%0b exp=1", stall); end
    ram_busy = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fill_release_stall got=%0b exp=0", stall); end
    n_cmp++; if (ram_addr !== 14'd1) begin n_bad++; $display("FAIL fill_drain_1 got=%0d exp=1", ram_addr); end
    tick();
    cpu_we = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fill_count_swap got=%0d exp=4", count); end
    for (int j = 2; j <= 5; j++) begin
      n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 14'(j) || ram_wdata !== 32'h100 + 32'(j)) begin
        n_bad++; $display("FAIL fill_drain_%0d got we=%0b addr=%0d data=%h exp we=1 addr=%0d data=%h",
                          j, ram_we, ram_addr, ram_wdata, j, 32'h100 + 32'(j));
      end
      tick();
    end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL fill_empty got=%0b exp=1", empty); end
    $display("test_fill_stall done");
  endtask

  task automatic test_forward_youngest();
    ram_busy = 1'b1; ram_rdata = 32'h99;
    cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h11;
    tick();
    cpu_wdata = 32'h22;
    tick();
    cpu_we = 1'b0; cpu_addr = 32'h20;
    #1;
    n_cmp++; if (cpu_rdata !== 32'h22) begin n_bad++; $display("FAIL fwd_youngest got=%h exp=22", cpu_rdata); end
    cpu_addr = 32'h24;
    #1;
    n_cmp++; if (cpu_rdata !== 32'h99) begin n_bad++; $display("FAIL fwd_miss got=%h exp=99", cpu_rdata); end
    cpu_addr = 32'h8000_0023;
    #1;
    n_cmp++; if (cpu_rdata !== 32'h22) begin n_bad++; $display("FAIL fwd_ignored_bits got=%h exp=22", cpu_rdata); end
    cpu_addr = 32'h20; ram_busy = 1'b0;
    tick();
    n_cmp++; if (cpu_rdata !== 32'h22) begin n_bad++; $display("FAIL fwd_draining got=%h exp=22", cpu_rdata); end
    tick();
    n_cmp++; if (cpu_rdata !== 32'h99) begin n_bad++; $display("FAIL fwd_drained got=%h exp=99", cpu_rdata); end
    $display("test_forward_youngest done");
  endtask

  task automatic test_same_cycle();
    ram_busy = 1'b0; ram_rdata = 32'h77;
    cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h55;
    #1;
    n_cmp++; if (cpu_rdata !== 32'h77) begin n_bad++; $display("FAIL same_cycle_nofwd got=%h exp=77", cpu_rdata); end
    tick();
    cpu_we = 1'b0;
    #1;
    n_cmp++; if (cpu_rdata !== 32'h55) begin n_bad++; $display("FAIL same_cycle_next got=%h exp=55", cpu_rdata); end
    tick();
    n_cmp++; if (cpu_rdata !== 32'h77) begin n_bad++; $display("FAIL same_cycle_drained got=%h exp=77", cpu_rdata); end
    $display("test_same_cycle done");
  endtask

  task automatic test_reset_mid();
    ram_busy = 1'b1;
    for (int k = 10; k <= 12; k++) begin
      cpu_we = 1'b1; cpu_addr = 32'(k * 4); cpu_wdata = 32'(k);
      tick();
    end
    cpu_we = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL mid_count_pre got=%0d exp=3", count); end
    rst = 1'b0; ram_busy = 1'b0;
    #1;
    n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL mid_ram_we_rst got=%0b exp=0", ram_we); end
    tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (count !== 3'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL mid_after got count=%0d empty=%0b exp count=0 empty=1", count, empty); end
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL mid_no_write_%0d got=%0b exp=0", c, ram_we); end
      tick();
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    ram_busy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cpu_we = 1'b1; cpu_addr = 32'(k * 4); cpu_wdata = 32'hA000 + 32'(k);
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL wrap_stall_%0d got=%0b exp=0", k, stall); end
      if (k >= 1) begin
        n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 14'(k - 1) || count !== 3'd1) begin
          n_bad++; $display("FAIL wrap_%0d got we=%0b addr=%0d count=%0d exp we=1 addr=%0d count=1",
                            k, ram_we, ram_addr, count, k - 1);
        end
      end
      tick();
    end
    cpu_we = 1'b0;
    #1;
    n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 14'd9 || ram_wdata !== 32'hA009) begin
      n_bad++; $display("FAIL wrap_last got we=%0b addr=%0d data=%h exp we=1 addr=9 data=a009", ram_we, ram_addr, ram_wdata);
    end
    tick();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty got=%0b exp=1", empty); end
    $display("test_back_to_back done");
  endtask

  initial begin
    rst = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; ram_busy = 1'b0; ram_rdata = '0;
    tick();
    test_reset();
    test_single_store();
    test_fill_stall();
    test_forward_youngest();
    test_same_cycle();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
